// File: rtl/approx_pkg.sv
// Purpose: shared widths and FSM state type for the approximate-multiplier error sweep.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package approx_pkg;

    localparam int W    = 4;        // operand width
    localparam int PW   = 2 * W;    // product width
    localparam int CNTW = 2 * W + 1;// error counter width (counts up to 2^(2W))
    localparam int SUMW = 4 * W;    // error-distance accumulator width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/abs_err_unit.sv
// Purpose: exact product of a sampled operand pair and its absolute distance to an approximate product.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: a1/b1 operands, y1 approximate product in; exact product and |exact - y1| out.
module abs_err_unit
    import approx_pkg::*;
#(
    parameter int OPW = approx_pkg::W
) (
    input  logic [OPW-1:0]   a1,
    input  logic [OPW-1:0]   b1,
    input  logic [2*OPW-1:0] y1,
    output logic [2*OPW-1:0] exact,
    output logic [2*OPW-1:0] ed
);

    logic [2*OPW-1:0] w_exact;

    // Operands zero-extended to product width so the multiply is never truncated.
    assign w_exact = {{OPW{1'b0}}, a1} * {{OPW{1'b0}}, b1};
    assign exact   = w_exact;
    assign ed      = (w_exact >= y1) ? (w_exact - y1) : (y1 - w_exact);

endmodule

// File: rtl/approx_err_sweep.sv
// Purpose: drives every operand pair to a multiplier under test and accumulates its error statistics.
// Latency: 2^(2W)+2 cycles from start to done (one sample stage plus one accumulate stage).
// Backpressure: none; start is ignored while busy, stats hold in DONE until the next start.
// Ports: clk/rst_n (sync, active low), start pulse; a_o/b_o operands out, y_i product in;
//        busy/done status; err_count, sum_ed, max_ed, max_a, max_b statistics.
module approx_err_sweep
    import approx_pkg::*;
#(
    parameter int W = approx_pkg::W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [W-1:0]      a_o,
    output logic [W-1:0]      b_o,
    input  logic [2*W-1:0]    y_i,
    output logic              busy,
    output logic              done,
    output logic [2*W:0]      err_count,
    output logic [4*W-1:0]    sum_ed,
    output logic [2*W-1:0]    max_ed,
    output logic [W-1:0]      max_a,
    output logic [W-1:0]      max_b
);

    localparam int LPW   = 2 * W;
    localparam int LCNTW = 2 * W + 1;
    localparam int LSUMW = 4 * W;
    localparam logic [LPW-1:0] LAST_IDX = '1;   // NPAIRS-1

    state_t           r_state;
    logic [LPW-1:0]   r_idx;
    logic             r_busy;
    logic             r_done;

    // Stage 1 sample registers
    logic             r_v1;
    logic [W-1:0]     r_a1;
    logic [W-1:0]     r_b1;
    logic [LPW-1:0]   r_y1;

    // Statistics
    logic [LCNTW-1:0] r_err_count;
    logic [LSUMW-1:0] r_sum_ed;
    logic [LPW-1:0]   r_max_ed;
    logic [W-1:0]     r_max_a;
    logic [W-1:0]     r_max_b;

    logic [LPW-1:0]   w_exact;
    logic [LPW-1:0]   w_ed;

    abs_err_unit #(.OPW(W)) u_abs_err (
        .a1    (r_a1),
        .b1    (r_b1),
        .y1    (r_y1),
        .exact (w_exact),
        .ed    (w_ed)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_v1        <= 1'b0;
            r_a1        <= '0;
            r_b1        <= '0;
            r_y1        <= '0;
            r_err_count <= '0;
            r_sum_ed    <= '0;
            r_max_ed    <= '0;
            r_max_a     <= '0;
            r_max_b     <= '0;
        end else begin
            // Stage 2: retire the sample captured on the previous edge.
            if (r_v1) begin
                if (w_ed != '0)
                    r_err_count <= r_err_count + 1'b1;
                r_sum_ed <= r_sum_ed + LSUMW'(w_ed);
                // Strict compare keeps the earliest pair on ties.
                if (w_ed > r_max_ed) begin
                    r_max_ed <= w_ed;
                    r_max_a  <= r_a1;
                    r_max_b  <= r_b1;
                end
            end

            r_v1 <= 1'b0;

            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= SWEEP;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err_count <= '0;
                        r_sum_ed    <= '0;
                        r_max_ed    <= '0;
                        r_max_a     <= '0;
                        r_max_b     <= '0;
                    end
                end
                SWEEP: begin
                    r_a1  <= a_o;
                    r_b1  <= b_o;
                    r_y1  <= y_i;
                    r_v1  <= 1'b1;
                    // Wraps to zero after the last pair, so operands read 0 outside SWEEP.
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX)
                        r_state <= DRAIN;
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign a_o       = r_idx[LPW-1:W];
    assign b_o       = r_idx[W-1:0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_count = r_err_count;
    assign sum_ed    = r_sum_ed;
    assign max_ed    = r_max_ed;
    assign max_a     = r_max_a;
    assign max_b     = r_max_b;

endmodule

// File: tb/tb_approx_err_sweep.sv
module tb_approx_err_sweep;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  a_o;
    logic [3:0]  b_o;
    logic [7:0]  y_i;
    logic        busy;
    logic        done;
    logic [8:0]  err_count;
    logic [15:0] sum_ed;
    logic [7:0]  max_ed;
    logic [3:0]  max_a;
    logic [3:0]  max_b;

    typedef struct {
        logic [8:0]  ec;
        logic [15:0] sum;
        logic [7:0]  mx;
        logic [3:0]  ma;
        logic [3:0]  mb;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   mode  = 0;

    approx_err_sweep dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_o       (a_o),
        .b_o       (b_o),
        .y_i       (y_i),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .sum_ed    (sum_ed),
        .max_ed    (max_ed),
        .max_a     (max_a),
        .max_b     (max_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // OR-accumulating approximate multiplier: partial products are ORed instead of added.
    function automatic logic [7:0] or4x4(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 4; i++)
            if (b[i]) r = r | ({4'd0, a} << i);
        return r;
    endfunction

    always_comb begin
        case (mode)
            0:       y_i = {4'd0, a_o} * {4'd0, b_o};
            1:       y_i = 8'd0;
            2:       y_i = ({4'd0, a_o} * {4'd0, b_o}) ^ 8'h01;
            default: y_i = or4x4(a_o, b_o);
        endcase
    end

    function automatic exp_t expected_for(input int m);
        exp_t e;
        int ex, y, ed;
        e.ec = 0; e.sum = 0; e.mx = 0; e.ma = 0; e.mb = 0;
        case (m)
            0: ;  // exact multiplier: all zero
            1: begin e.ec = 9'd225; e.sum = 16'd14400; e.mx = 8'd225; e.ma = 4'd15; e.mb = 4'd15; end
            2: begin e.ec = 9'd256; e.sum = 16'd256;   e.mx = 8'd1;   e.ma = 4'd0;  e.mb = 4'd0;  end
            default: begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        ex = a * b;
                        y  = int'(or4x4(4'(a), 4'(b)));
                        ed = (ex >= y) ? ex - y : y - ex;
                        if (ed != 0) e.ec = e.ec + 1'b1;
                        e.sum = e.sum + 16'(ed);
                        if (ed > int'(e.mx)) begin
                            e.mx = 8'(ed); e.ma = 4'(a); e.mb = 4'(b);
                        end
                    end
                end
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: on each rising edge of done, pop the oldest expectation and compare.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && done && !prev_done) begin
                if (q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL sb_unexpected_done: got done with empty queue expected none");
                end else begin
                    e = q.pop_front();
                    chk("err_count", 32'(err_count), 32'(e.ec));
                    chk("sum_ed",    32'(sum_ed),    32'(e.sum));
                    chk("max_ed",    32'(max_ed),    32'(e.mx));
                    chk("max_a",     32'(max_a),     32'(e.ma));
                    chk("max_b",     32'(max_b),     32'(e.mb));
                end
            end
            prev_done = done;
        end
    end

    task automatic run_sweep(input int m, input bit midstart);
        mode = m;
        @(negedge clk);
        q.push_back(expected_for(m));
        start = 1'b1;
        @(posedge clk);   // E0
        #1 start = 1'b0;
        chk("busy_after_E0", 32'(busy), 32'd1);
        chk("a_o_after_E0",  32'(a_o),  32'd0);
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk);
            #1;
            start = (midstart && k == 49) ? 1'b1 : 1'b0;
            if (k == 17) begin
                chk("a_o_idx17", 32'(a_o), 32'd1);
                chk("b_o_idx17", 32'(b_o), 32'd1);
            end
            if (k == 100) chk("done_mid_sweep", 32'(done), 32'd0);
        end
        chk("busy_after_E256", 32'(busy), 32'd1);
        chk("done_after_E256", 32'(done), 32'd0);
        chk("a_o_in_drain",    32'(a_o),  32'd0);
        @(posedge clk);   // E257
        #1;
        chk("done_after_E257", 32'(done), 32'd1);
        chk("busy_after_E257", 32'(busy), 32'd0);
        @(negedge clk);   // let the monitor see the done edge
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_a_o",       32'(a_o),       32'd0);
        chk("rst_b_o",       32'(b_o),       32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_sum_ed",    32'(sum_ed),    32'd0);
        chk("rst_max_ed",    32'(max_ed),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep(0, 1'b0);
        run_sweep(1, 1'b0);
        run_sweep(2, 1'b0);
        run_sweep(3, 1'b1);   // start pulsed mid-sweep is ignored
        run_sweep(3, 1'b0);   // restart from DONE gives identical stats

        // Abort a sweep with reset after 100 cycles; nothing is queued for it.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_done",      32'(done),      32'd0);
        chk("abort_a_o",       32'(a_o),       32'd0);
        chk("abort_b_o",       32'(b_o),       32'd0);
        chk("abort_err_count", 32'(err_count), 32'd0);
        chk("abort_sum_ed",    32'(sum_ed),    32'd0);
        chk("abort_max_ed",    32'(max_ed),    32'd0);
        chk("abort_max_a",     32'(max_a),     32'd0);
        chk("abort_max_b",     32'(max_b),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep(1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/approx_err_sweep.md
Name: approx_err_sweep

Overview:
- Self-checking sweep harness stage wrapped around a 4x4 approximate multiplier (e.g. or_4x4).
- Upstream role: drives every operand pair (a,b) exhaustively to the multiplier under test.
- Downstream role: consumes the multiplier's combinational product Y and compares it against an internally computed exact product.
- Accumulates error metrics (error count, sum of error distance, max error distance with its operands) for on-chip characterisation of approximate multipliers.

Parameters:
- W, 4, operand width; multiplier product width is 2W.
- NPAIRS, 2**(2W), number of operand pairs swept (derived, not overridable).
- SUMW, 4W, width of the error-distance accumulator. Holds the worst case 2^(2W)·(2^(2W)−1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle or done.
- a_o  out  W  operand A to the multiplier under test.
- b_o  out  W  operand B to the multiplier under test.
- y_i  in  2W  approximate product from the multiplier under test (combinational from a_o/b_o).
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  high in DONE; stats are final.
- err_count  out  2W+1  number of pairs with error distance ≠ 0.
- sum_ed  out  SUMW  Σ|exact − y|.
- max_ed  out  2W  largest |exact − y| seen.
- max_a  out  W  operand A at first occurrence of max_ed.
- max_b  out  W  operand B at first occurrence of max_ed.

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous, active-low on rst_n; all state updates on the rising edge of clk.
- Reset values (rst_n=0 at an edge): state=IDLE, index=0, v1=0; all outputs 0. This also applies mid-sweep: the sweep is abandoned and partial stats are cleared.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE→SWEEP on start. At the same edge, clear all stats and set index=0.
  - SWEEP: index increments each cycle. At index=NPAIRS−1, the next state is DRAIN.
  - DRAIN: one cycle, retires the last sample. Next state is DONE.
  - DONE: done=1; stats held. On start: same action as from IDLE.
  - start during SWEEP/DRAIN is ignored.
- Operand drive: a_o=index[2W−1:W], b_o=index[W−1:0], both registered. They are 0 outside SWEEP.
- Stage 1 (sample): in SWEEP, each edge captures {a_o, b_o, y_i} into {a1, b1, y1} and sets v1=1. Otherwise v1=0.
- Stage 2 (accumulate), when v1=1:
  - exact = a1·b1 (2W bits, unsigned).
  - ed = |exact − y1| (2W bits).
  - If ed≠0, increment err_count.
  - sum_ed += ed.
  - If ed > max_ed (strict), load max_ed, max_a, max_b. Ties keep the first occurrence in index order.
- Timing: with start sampled at edge E0, pairs are driven E0..E255 (W=4). DRAIN follows edge E256; done=1 and final stats are valid after edge E257. busy=1 after E0 through E256.
- No overflow is possible at the given widths. No saturation logic.

Decomposition:
- Package approx_pkg holds:
  - W default;
  - derived widths PW=2W, CNTW=2W+1, SUMW=4W;
  - state enum {IDLE, SWEEP, DRAIN, DONE}.
- One sub-module, abs_err_unit: combinational. Inputs a1, b1, y1; outputs exact and ed. Unit-testable alone.

Test Plan:
- y_i = exact a_o·b_o → done after 258 cycles from start. err_count=0, sum_ed=0, max_ed=0, max_a=0, max_b=0.
- y_i tied 0 → err_count=225, sum_ed=14400, max_ed=225, max_a=15, max_b=15.
- y_i = (a_o·b_o) ^ 8'h01 → err_count=256, sum_ed=256, max_ed=1, max_a=0, max_b=0 (first occurrence).
- y_i driven by or_4x4 → stats match a software model of or_4x4 over all 256 pairs. busy/done timing checked against E0/E256/E257.
- rst_n=0 at cycle 100 of a sweep → state IDLE, all outputs 0 next edge. A following start gives a full clean sweep.
- start pulsed mid-SWEEP is ignored (done still at E257). start in DONE clears stats and restarts; the second sweep's stats equal the first's.
